// File: rtl/mlp_mem_pkg.sv
// Shared definitions for the MLP SDRAM memory masters.
package mlp_mem_pkg;

  // Bridge word size in bytes (128-bit data bus).
  localparam int unsigned INTERFACE_WIDTH_BYTES = 16;

  // Default result region, placed above the image buffer.
  localparam int unsigned RESULT_BASE_ADDR = 204800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } writer_state_t;

endpackage

// File: rtl/byte_lane_packer.sv
// Packs a byte stream little-endian into one bus word, tracking lane enables.
module byte_lane_packer
  import mlp_mem_pkg::*;
#(
  parameter int unsigned WIDTH_BYTES = INTERFACE_WIDTH_BYTES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     load,
  input  logic [7:0]               byte_in,
  output logic [WIDTH_BYTES*8-1:0] data,
  output logic [WIDTH_BYTES-1:0]   byte_enable,
  output logic                     full
);

  localparam int unsigned LANE_BITS = $clog2(WIDTH_BYTES);

  logic [LANE_BITS-1:0] lane;

  // Lane counter, data and enable registers; clear wins over load.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane        <= '0;
      data        <= '0;
      byte_enable <= '0;
    end else if (load) begin
      data[{lane, 3'b000} +: 8] <= byte_in;
      byte_enable[lane]         <= 1'b1;
      lane                      <= lane + LANE_BITS'(1);
    end
  end

  // High while the next load lands in the top lane and completes the word.
  assign full = (lane == LANE_BITS'(WIDTH_BYTES - 1));

endmodule

// File: rtl/sdram_result_writer.sv
// Avalon-style write master: packs a byte stream into bus words and writes
// them to consecutive word addresses through the SDRAM bridge.
module sdram_result_writer
  import mlp_mem_pkg::*;
#(
  parameter int unsigned INTERFACE_WIDTH_BITS = 128,
  parameter int unsigned INTERFACE_ADDR_BITS  = 26,
  parameter int unsigned COUNT_BITS           = 16
) (
  input  logic                              interface_clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [INTERFACE_ADDR_BITS-1:0]    base_address,
  input  logic [COUNT_BITS-1:0]             byte_count,
  input  logic [7:0]                        in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [INTERFACE_ADDR_BITS-1:0]    interface_address,
  output logic [INTERFACE_WIDTH_BITS/8-1:0] interface_byte_enable,
  output logic                              interface_write,
  output logic                              interface_read,
  output logic [INTERFACE_WIDTH_BITS-1:0]   interface_write_data,
  input  logic                              interface_acknowledge,
  output logic                              busy,
  output logic                              done,
  output logic [COUNT_BITS-1:0]             bytes_written
);

  localparam int unsigned WIDTH_BYTES = INTERFACE_WIDTH_BITS / 8;
  localparam int unsigned POP_BITS    = $clog2(WIDTH_BYTES) + 1;

  writer_state_t         state;
  writer_state_t         state_next;
  logic [COUNT_BITS-1:0] remaining;
  logic                  start_take;
  logic                  accept;
  logic                  ack;
  logic                  word_full;
  logic                  last_byte;
  logic [POP_BITS-1:0]   lanes_used;

  assign start_take = (state == IDLE) && start;
  assign accept     = (state == FILL) && in_valid;
  assign ack        = (state == WRITE) && interface_acknowledge;
  assign last_byte  = word_full || (remaining == COUNT_BITS'(1));

  byte_lane_packer #(
    .WIDTH_BYTES (WIDTH_BYTES)
  ) u_packer (
    .clk         (interface_clock),
    .reset       (reset),
    .clear       (start_take || ack),
    .load        (accept),
    .byte_in     (in_data),
    .data        (interface_write_data),
    .byte_enable (interface_byte_enable),
    .full        (word_full)
  );

  // State register.
  always_ff @(posedge interface_clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = (byte_count == '0) ? DONE : FILL;
      FILL:  if (accept && last_byte) state_next = WRITE;
      WRITE: if (interface_acknowledge) state_next = (remaining == '0) ? DONE : FILL;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    in_ready        = 1'b0;
    interface_write = 1'b0;
    interface_read  = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    unique case (state)
      IDLE:  ;
      FILL:  begin in_ready = 1'b1; busy = 1'b1; end
      WRITE: begin interface_write = 1'b1; busy = 1'b1; end
      DONE:  begin done = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  // Number of lanes committed by the word currently on the bus.
  always_comb begin
    lanes_used = '0;
    for (int unsigned i = 0; i < WIDTH_BYTES; i++) begin
      lanes_used = lanes_used + POP_BITS'(interface_byte_enable[i]);
    end
  end

  // Word address, bytes left to accept and committed byte count.
  always_ff @(posedge interface_clock) begin
    if (reset) begin
      interface_address <= '0;
      remaining         <= '0;
      bytes_written     <= '0;
    end else if (start_take) begin
      interface_address <= base_address & ~INTERFACE_ADDR_BITS'(WIDTH_BYTES - 1);
      remaining         <= byte_count;
      bytes_written     <= '0;
    end else if (accept) begin
      remaining <= remaining - COUNT_BITS'(1);
    end else if (ack) begin
      interface_address <= interface_address + INTERFACE_ADDR_BITS'(WIDTH_BYTES);
      bytes_written     <= bytes_written + COUNT_BITS'(lanes_used);
    end
  end

endmodule

// File: tb/tb_sdram_result_writer.sv
// Directed bench for sdram_result_writer with a write scoreboard.
module tb_sdram_result_writer;
  import mlp_mem_pkg::*;

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 128;
  localparam int unsigned BW = 16;
  localparam int unsigned CW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_address;
  logic [CW-1:0] byte_count;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] interface_address;
  logic [BW-1:0] interface_byte_enable;
  logic          interface_write;
  logic          interface_read;
  logic [DW-1:0] interface_write_data;
  logic          interface_acknowledge;
  logic          busy;
  logic          done;
  logic [CW-1:0] bytes_written;

  int  total = 0;
  int  bad   = 0;
  wr_t sb_q[$];

  int  ack_delay  = 0;
  bit  always_ack = 1'b0;
  int  wcnt       = 0;

  bit  in_wr       = 1'b0;
  wr_t cap;
  int  wr_len      = 0;
  int  last_wr_len = 0;
  int  write_cycles = 0;

  sdram_result_writer dut (
    .interface_clock       (clk),
    .reset                 (reset),
    .start                 (start),
    .base_address          (base_address),
    .byte_count            (byte_count),
    .in_data               (in_data),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .interface_address     (interface_address),
    .interface_byte_enable (interface_byte_enable),
    .interface_write       (interface_write),
    .interface_read        (interface_read),
    .interface_write_data  (interface_write_data),
    .interface_acknowledge (interface_acknowledge),
    .busy                  (busy),
    .done                  (done),
    .bytes_written         (bytes_written)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic wr_t mk(input logic [AW-1:0] addr, input logic [7:0] first, input int unsigned n);
    wr_t w;
    w.addr = addr;
    w.data = '0;
    w.be   = '0;
    for (int unsigned i = 0; i < n; i++) begin
      w.data[i*8 +: 8] = first + 8'(i);
      w.be[i]          = 1'b1;
    end
    return w;
  endfunction

  task automatic push_model(input logic [AW-1:0] base, input int unsigned count, input logic [7:0] first);
    logic [AW-1:0] a;
    int unsigned   n;
    a = base & ~AW'(15);
    for (int unsigned w = 0; w < count; w += 16) begin
      n = ((count - w) > 16) ? 16 : (count - w);
      sb_q.push_back(mk(a, first + 8'(w), n));
      a = a + AW'(16);
    end
  endtask

  // Bridge model: acknowledge after ack_delay extra write cycles, or always.
  initial begin
    interface_acknowledge = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      interface_acknowledge = always_ack || (interface_write && (wcnt == ack_delay));
      wcnt = interface_write ? wcnt + 1 : 0;
    end
  end

  // Monitor: write stability, back-pressure, and scoreboard on acknowledge.
  always @(negedge clk) begin
    if (interface_write) begin
      write_cycles++;
      if (!in_wr) begin
        in_wr    = 1'b1;
        wr_len   = 1;
        cap.addr = interface_address;
        cap.data = interface_write_data;
        cap.be   = interface_byte_enable;
      end else begin
        wr_len++;
        check("wr addr stable", DW'(interface_address), DW'(cap.addr));
        check("wr data stable", interface_write_data, cap.data);
        check("wr be stable", DW'(interface_byte_enable), DW'(cap.be));
      end
      check("in_ready low in write", DW'(in_ready), DW'(0));
      if (interface_acknowledge) begin
        last_wr_len = wr_len;
        in_wr       = 1'b0;
        if (sb_q.size() == 0) begin
          check("unexpected write", DW'(1), DW'(0));
        end else begin
          wr_t e;
          e = sb_q.pop_front();
          check("wr addr", DW'(interface_address), DW'(e.addr));
          check("wr data", interface_write_data, e.data);
          check("wr be", DW'(interface_byte_enable), DW'(e.be));
        end
      end
    end else begin
      in_wr = 1'b0;
    end
    if (interface_read) check("read asserted", DW'(interface_read), DW'(0));
  end

  task automatic send_byte(input logic [7:0] b, output bit ok);
    in_data  = b;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int unsigned count);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check("done seen", DW'(ok), DW'(1));
    check("bytes_written", DW'(bytes_written), DW'(count));
    @(negedge clk);
    check("done one cycle", DW'(done), DW'(0));
    check("idle after done", DW'(busy), DW'(0));
    check("all writes seen", DW'(sb_q.size()), DW'(0));
  endtask

  task automatic xfer(input logic [AW-1:0] base, input int unsigned count,
                      input logic [7:0] first, input bit model, input int stray_at);
    bit ok;
    if (model) push_model(base, count, first);
    base_address = base;
    byte_count   = CW'(count);
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int unsigned i = 0; i < count; i++) begin
      if (int'(i) == stray_at) begin
        start        = 1'b1;
        base_address = 26'h1234560;
        byte_count   = 16'd3;
      end
      send_byte(first + 8'(i), ok);
      start = 1'b0;
      if (!ok) begin
        check("byte accept timeout", DW'(0), DW'(1));
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    wait_done(count);
  endtask

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int wc0;
    reset        = 1'b1;
    start        = 1'b0;
    base_address = '0;
    byte_count   = '0;
    in_data      = '0;
    in_valid     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", DW'(in_ready), DW'(0));
    check("rst write", DW'(interface_write), DW'(0));
    check("rst busy", DW'(busy), DW'(0));
    check("rst done", DW'(done), DW'(0));
    check("rst addr", DW'(interface_address), DW'(0));
    check("rst be", DW'(interface_byte_enable), DW'(0));
    check("rst data", interface_write_data, DW'(0));
    check("rst bytes_written", DW'(bytes_written), DW'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Two full words, immediate acknowledge.
    sb_q.push_back('{addr: 26'd204800, data: 128'h0F0E0D0C0B0A09080706050403020100, be: 16'hFFFF});
    sb_q.push_back('{addr: 26'd204816, data: 128'h1F1E1D1C1B1A19181716151413121110, be: 16'hFFFF});
    xfer(AW'(RESULT_BASE_ADDR), 32, 8'h00, 1'b0, -1);
    repeat (3) @(negedge clk);
    check("bytes_written hold", DW'(bytes_written), DW'(32));

    // Partial final word, acknowledge held high throughout, stray start in FILL.
    always_ack = 1'b1;
    sb_q.push_back('{addr: 26'd208896, data: 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, be: 16'hFFFF});
    sb_q.push_back('{addr: 26'd208912, data: 128'h000000000000000000000000B3B2B1B0, be: 16'h000F});
    xfer(26'd208896, 20, 8'hA0, 1'b0, 5);
    always_ack = 1'b0;

    // Acknowledge delayed by five cycles.
    ack_delay = 5;
    xfer(26'h0010000, 32, 8'h40, 1'b1, -1);
    check("write cycles per word", DW'(last_wr_len), DW'(6));
    ack_delay = 0;

    // Zero-length transfer.
    wc0          = write_cycles;
    base_address = 26'h0000100;
    byte_count   = '0;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("zero done", DW'(done), DW'(1));
    check("zero busy", DW'(busy), DW'(1));
    @(negedge clk);
    check("zero done once", DW'(done), DW'(0));
    check("zero idle", DW'(busy), DW'(0));
    check("zero bytes_written", DW'(bytes_written), DW'(0));
    check("zero no write", DW'(write_cycles), DW'(wc0));

    // Reset during a write, then restart from a new base.
    ack_delay    = 5;
    base_address = 26'h0100000;
    byte_count   = 16'd20;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h80 + 8'(i), ok);
      if (!ok) check("byte accept timeout", DW'(0), DW'(1));
    end
    in_valid = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (interface_write) begin
        ok = 1'b1;
        break;
      end
    end
    check("write before reset", DW'(ok), DW'(1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid rst write", DW'(interface_write), DW'(0));
    check("mid rst busy", DW'(busy), DW'(0));
    check("mid rst addr", DW'(interface_address), DW'(0));
    check("mid rst bytes_written", DW'(bytes_written), DW'(0));
    ack_delay = 0;
    xfer(26'h0200000, 16, 8'h60, 1'b1, -1);

    // Address wrap with an unaligned base.
    xfer(26'h3FFFFF7, 32, 8'hC0, 1'b1, -1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_result_writer.md
Name: sdram_result_writer

Overview:
Avalon-style write master, the write-direction counterpart of the SDRAM image/weight reader. It accepts a byte stream from the MLP datapath, such as hidden-layer activations or classification scores, over a valid/ready handshake. Bytes are packed little-endian into 128-bit words, matching the reader's unpack order of byte 0 at bits [7:0]. Each word is written to SDRAM through the external bridge at consecutive 16-byte addresses.

Parameters:
INTERFACE_WIDTH_BITS, 128, width of bridge data bus
INTERFACE_ADDR_BITS, 26, width of bridge byte address
COUNT_BITS, 16, width of the byte_count and bytes_written counters

Ports:
interface_clock  in  1  sole clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle request to begin a transfer
base_address  in  INTERFACE_ADDR_BITS  byte address of first word; bits [3:0] ignored (forced 0)
byte_count  in  COUNT_BITS  number of bytes to write
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  writer accepts byte this cycle
interface_address  out  INTERFACE_ADDR_BITS  bridge byte address
interface_byte_enable  out  INTERFACE_WIDTH_BITS/8  lane enables
interface_write  out  1  write request
interface_read  out  1  constant 0
interface_write_data  out  INTERFACE_WIDTH_BITS  packed word
interface_acknowledge  in  1  bridge accepted the write this cycle
busy  out  1  high when not IDLE
done  out  1  one-cycle pulse at end of transfer
bytes_written  out  COUNT_BITS  bytes committed to SDRAM in current/last transfer

Behaviour:
- Reset (sync, high) values: state IDLE; in_ready, interface_write, done, busy = 0; interface_address = 0; interface_byte_enable = 0; interface_write_data = 0; bytes_written = 0.
- Reset asserted mid-write drops interface_write at that edge; the partial word is discarded.
- IDLE:
  - start latches base_address & ~0xF, byte_count into remaining, lane = 0, byte-enable reg = 0, data reg = 0, bytes_written = 0.
  - If byte_count == 0, go to DONE; otherwise go to FILL.
  - start is ignored in every other state.
- FILL:
  - in_ready = 1.
  - On in_valid & in_ready, the byte goes to data lane `lane`, byte-enable bit `lane` is set, `lane` increments, and remaining decrements.
  - Go to WRITE the cycle after the byte that fills lane 15 or makes remaining = 0.
  - No byte is accepted in the transition cycle.
- WRITE:
  - in_ready = 0; interface_write = 1.
  - interface_address, interface_write_data and interface_byte_enable are registered and held stable until the acknowledge cycle.
  - On interface_acknowledge:
    - bytes_written += popcount(byte enables).
    - interface_address += 16; wraps modulo 2^INTERFACE_ADDR_BITS with no error.
    - data and byte-enable regs clear; lane = 0.
    - Next state: DONE if remaining == 0, else FILL.
  - interface_write deasserts the cycle after acknowledge.
- DONE: done = 1 for exactly one cycle, then IDLE. bytes_written holds until the next start.
- Partial final word: unused lanes have enable 0 and data 0.
- No overlap of fill and write; minimum 17 cycles per full word with immediate acknowledge.
- Unrelated acknowledge (outside WRITE) is ignored.

Decomposition:
- Shared package mlp_mem_pkg holds:
  - writer state enum {IDLE, FILL, WRITE, DONE};
  - INTERFACE_WIDTH_BYTES;
  - RESULT_BASE_ADDR = 204800, the default region above the image buffer.
- One sub-module, byte_lane_packer: lane counter, byte-enable reg and data reg, with load/clear/full outputs.
- The FSM and address/count logic stay in the top module.

Test Plan:
1. base 204800, count 32, bytes 0x00..0x1F, acknowledge same cycle as write:
   - two writes, addr 204800 data 0x0F0E…0100 BE 0xFFFF, then 204816 data 0x1F1E…1110 BE 0xFFFF;
   - done pulse once; bytes_written = 32.
2. count 20, bytes 0xA0..0xB3:
   - second write BE 0x000F, data lanes 0-3 = B0..B3, others 0;
   - bytes_written = 20.
3. acknowledge delayed 5 cycles:
   - address/data/BE stable across all 6 write cycles; in_ready = 0 throughout;
   - next byte is not consumed before the acknowledge.
4. count 0: done one cycle after the IDLE state returns; interface_write never asserted; bytes_written = 0.
5. start pulsed while busy is ignored. Reset asserted during WRITE:
   - next cycle interface_write = 0, busy = 0;
   - a new start then writes from the new base.
6. base 0x3FFFFF0 (unaligned variant 0x3FFFFF7 gives the same result), count 32: writes at 0x3FFFFF0 then 0x0000000.
